// File: rtl/gobang_move_ctrl.sv
// GoBang move sequencer: debounces the put key, validates and writes a stone,
// scans four line directions for a win, then switches turn or locks the game.
module gobang_move_ctrl #(
  parameter int BOARD_N    = 15,
  parameter int DEB_CYCLES = 1000000,
  parameter int WIN_LEN    = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       put_n,
  input  logic [7:0] coord,
  output logic [7:0] mem_addr,
  input  logic [1:0] mem_rdata,
  output logic       mem_we,
  output logic [1:0] mem_wdata,
  output logic       turn,
  output logic       change_turn,
  output logic [1:0] win,
  output logic       busy,
  output logic       reject
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0]     DEB_MAX = DW'(DEB_CYCLES);
  localparam logic [3:0]        LAST_RC = 4'(BOARD_N - 1);
  localparam logic [4:0]        N_EXT   = 5'(BOARD_N);
  localparam logic signed [7:0] N_S     = 8'(BOARD_N);
  localparam logic [3:0]        K_LAST  = 4'(WIN_LEN - 1);
  localparam logic [3:0]        WIN_CNT = 4'(WIN_LEN);

  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_RD_CELL, S_CHK_CELL, S_WRITE,
    S_STEP_RD, S_STEP_CHK, S_SWITCH, S_WIN
  } state_t;

  state_t state_reg, state_next;

  logic          put_s1_reg, put_s2_reg, press_reg;
  logic [DW-1:0] deb_cnt_reg;

  logic [3:0] clr_row_reg, clr_row_next, clr_col_reg, clr_col_next;
  logic [3:0] row_reg, row_next, col_reg, col_next;
  logic       turn_reg, turn_next;
  logic [1:0] win_reg, win_next;
  logic [3:0] count_reg, count_next;
  logic [1:0] dir_reg, dir_next;
  logic       side_reg, side_next;
  logic [3:0] k_reg, k_next;
  logic       side_done;
  logic [1:0] code;

  logic signed [7:0] k_s, dr_s, dc_s, tr_s, tc_s;
  logic              tgt_ok;

  // Synchroniser flops idle at the released key level so no count starts out of reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      put_s1_reg  <= 1'b1;
      put_s2_reg  <= 1'b1;
      deb_cnt_reg <= '0;
      press_reg   <= 1'b0;
    end else begin
      put_s1_reg <= put_n;
      put_s2_reg <= put_s1_reg;
      press_reg  <= !put_s2_reg && (deb_cnt_reg == DEB_MAX - 1'b1);
      if (put_s2_reg)
        deb_cnt_reg <= '0;
      else if (deb_cnt_reg != DEB_MAX)
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
    end
  end

  assign code = turn_reg ? 2'b10 : 2'b01;

  // Scan target: (row,col) + k*(dr,dc) on the + side, negated on the - side.
  always_comb begin
    k_s  = {4'b0000, k_reg};
    dr_s = k_s;
    dc_s = k_s;
    case (dir_reg)
      2'd0:    dr_s = '0;
      2'd1:    dc_s = '0;
      2'd3:    dc_s = -k_s;
      default: dr_s = k_s;
    endcase
    if (side_reg) begin
      dr_s = -dr_s;
      dc_s = -dc_s;
    end
    tr_s   = $signed({4'b0000, row_reg}) + dr_s;
    tc_s   = $signed({4'b0000, col_reg}) + dc_s;
    tgt_ok = !tr_s[7] && (tr_s < N_S) && !tc_s[7] && (tc_s < N_S);
  end

  always_comb begin
    state_next   = state_reg;
    clr_row_next = clr_row_reg;
    clr_col_next = clr_col_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    turn_next    = turn_reg;
    win_next     = win_reg;
    count_next   = count_reg;
    dir_next     = dir_reg;
    side_next    = side_reg;
    k_next       = k_reg;
    side_done    = 1'b0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wdata    = 2'b00;
    reject       = 1'b0;
    change_turn  = 1'b0;

    case (state_reg)
      S_CLEAR: begin
        mem_addr = {clr_row_reg, clr_col_reg};
        mem_we   = resetn;
        if (clr_col_reg == LAST_RC) begin
          clr_col_next = '0;
          if (clr_row_reg == LAST_RC) begin
            clr_row_next = '0;
            state_next   = S_IDLE;
          end else begin
            clr_row_next = clr_row_reg + 1'b1;
          end
        end else begin
          clr_col_next = clr_col_reg + 1'b1;
        end
      end
      S_IDLE: begin
        if (press_reg) begin
          row_next = coord[7:4];
          col_next = coord[3:0];
          if (({1'b0, coord[7:4]} >= N_EXT) || ({1'b0, coord[3:0]} >= N_EXT))
            reject = 1'b1;
          else
            state_next = S_RD_CELL;
        end
      end
      S_RD_CELL: begin
        mem_addr   = {row_reg, col_reg};
        state_next = S_CHK_CELL;
      end
      S_CHK_CELL: begin
        if (mem_rdata != 2'b00) begin
          reject     = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_addr   = {row_reg, col_reg};
        mem_we     = 1'b1;
        mem_wdata  = code;
        count_next = 4'd1;
        dir_next   = 2'd0;
        side_next  = 1'b0;
        k_next     = 4'd1;
        state_next = S_STEP_RD;
      end
      S_STEP_RD: begin
        // Off-board neighbours end the side without touching memory.
        if (tgt_ok) begin
          mem_addr   = {tr_s[3:0], tc_s[3:0]};
          state_next = S_STEP_CHK;
        end else begin
          side_done = 1'b1;
        end
      end
      S_STEP_CHK: begin
        if (mem_rdata == code) begin
          count_next = count_reg + 1'b1;
          if (k_reg == K_LAST) begin
            side_done = 1'b1;
          end else begin
            k_next     = k_reg + 1'b1;
            state_next = S_STEP_RD;
          end
        end else begin
          side_done = 1'b1;
        end
      end
      S_SWITCH: begin
        change_turn = 1'b1;
        turn_next   = ~turn_reg;
        state_next  = S_IDLE;
      end
      S_WIN: begin
        win_next = win_reg | code;
      end
      default: state_next = S_CLEAR;
    endcase

    if (side_done) begin
      k_next = 4'd1;
      if (!side_reg) begin
        side_next  = 1'b1;
        state_next = S_STEP_RD;
      end else if (count_next >= WIN_CNT) begin
        state_next = S_WIN;
      end else if (dir_reg == 2'd3) begin
        state_next = S_SWITCH;
      end else begin
        dir_next   = dir_reg + 1'b1;
        side_next  = 1'b0;
        count_next = 4'd1;
        state_next = S_STEP_RD;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= S_CLEAR;
      clr_row_reg <= '0;
      clr_col_reg <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      turn_reg    <= 1'b0;
      win_reg     <= 2'b00;
      count_reg   <= '0;
      dir_reg     <= '0;
      side_reg    <= 1'b0;
      k_reg       <= '0;
    end else begin
      state_reg   <= state_next;
      clr_row_reg <= clr_row_next;
      clr_col_reg <= clr_col_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      turn_reg    <= turn_next;
      win_reg     <= win_next;
      count_reg   <= count_next;
      dir_reg     <= dir_next;
      side_reg    <= side_next;
      k_reg       <= k_next;
    end
  end

  assign turn = turn_reg;
  assign win  = win_reg;
  assign busy = (state_reg != S_IDLE);

endmodule
